fp32_series_accumulator: RTL and testbench

//  Sequencer that sums a stream of FP32 series terms (Taylor/polynomial terms from the

---
 rtl/fp32_series_accumulator_if.sv | 65 ++++++
 rtl/fp32_series_accumulator.sv | 159 +++++++++++++++
 tb/tb_fp32_series_accumulator.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_series_accumulator_if.sv
// ----------------------------------------------------------------------------
// fp32_series_accumulator_if
// Purpose : Bundles the term stream, adder handshake and result handshake of the
//           FP32 series accumulator into one interface.
// Modports:
//   slave  - the accumulator itself (consumes terms, drives the adder, emits sum)
//   master - the environment (term source, FP32 adder, downstream sink)
// Signals (direction seen from the accumulator):
//   term_i/term_valid_i/term_last_i/term_ready_o   term stream handshake
//   add_a_o/add_b_o/add_valid_o                    adder operands + start pulse
//   add_result_i/add_done_i                        adder result + done level
//   sum_o/sum_valid_o/sum_ready_i                  finished sum handshake
//   term_count_o                                   terms accepted in current series
//   busy_o                                         accumulator not idle
//   timeout_o                                      sticky watchdog flag
// Build option: FP_ACC_TIMEOUT_EN adds timeout_o.
// ----------------------------------------------------------------------------
interface fp32_series_accumulator_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0] term_i;
   logic                  term_valid_i;
   logic                  term_last_i;
   logic                  term_ready_o;
   logic [DATA_WIDTH-1:0] add_a_o;
   logic [DATA_WIDTH-1:0] add_b_o;
   logic                  add_valid_o;
   logic [DATA_WIDTH-1:0] add_result_i;
   logic                  add_done_i;
   logic [DATA_WIDTH-1:0] sum_o;
   logic                  sum_valid_o;
   logic                  sum_ready_i;
   logic [CNT_WIDTH-1:0]  term_count_o;
   logic                  busy_o;
`ifdef FP_ACC_TIMEOUT_EN
   logic                  timeout_o;
`endif

   modport slave (
`ifdef FP_ACC_TIMEOUT_EN
      output timeout_o,
`endif
      input  term_i, term_valid_i, term_last_i,
      output term_ready_o,
      output add_a_o, add_b_o, add_valid_o,
      input  add_result_i, add_done_i,
      output sum_o, sum_valid_o,
      input  sum_ready_i,
      output term_count_o, busy_o
   );

   modport master (
`ifdef FP_ACC_TIMEOUT_EN
      input  timeout_o,
`endif
      output term_i, term_valid_i, term_last_i,
      input  term_ready_o,
      input  add_a_o, add_b_o, add_valid_o,
      output add_result_i, add_done_i,
      input  sum_o, sum_valid_o,
      output sum_ready_i,
      input  term_count_o, busy_o
   );
endinterface

// File: rtl/fp32_series_accumulator.sv
// ----------------------------------------------------------------------------
// fp32_series_accumulator
// Purpose : Sequences a stream of FP32 series terms through an external FP32
//           adder and presents the finished sum downstream. The first add of a
//           series is always (+0.0) + term0; no arithmetic is done here.
// Ports   :
//   clkn_i  - clock, all logic on the rising edge
//   rst_i   - synchronous reset, active-high
//   bus     - fp32_series_accumulator_if.slave (term stream, adder handshake,
//             sum handshake, term_count_o, busy_o, optional timeout_o)
// Build option: FP_ACC_TIMEOUT_EN enables a WAIT watchdog of TIMEOUT_CYCLES
//           cycles and the sticky timeout_o flag. Without it WAIT holds until
//           the adder reports done.
// ----------------------------------------------------------------------------
module fp32_series_accumulator #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_TERMS      = 8,
   parameter int unsigned CNT_WIDTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                      clkn_i,
   input logic                      rst_i,
   fp32_series_accumulator_if.slave bus
);

   if (DATA_WIDTH != 32 || NUM_TERMS == 0 || (2 ** CNT_WIDTH) <= NUM_TERMS ||
       TIMEOUT_CYCLES == 0) begin : g_cfg_err
      $error("fp32_series_accumulator: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StNext,
      StOut
   } state_e;

   state_e                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
   logic [DATA_WIDTH-1:0] r_term, w_term_nxt;
   logic [CNT_WIDTH-1:0]  r_count, w_count_nxt;
   logic                  r_last, w_last_nxt;
   logic                  w_term_ready;
   logic                  w_xfer;
   logic [CNT_WIDTH:0]    w_count_inc;

`ifdef FP_ACC_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WdW-1:0] r_wdog, w_wdog_nxt;
   logic           r_timeout, w_timeout_nxt;
`endif

   // Ready is a pure state decode so the source sees it without a cycle of lag.
   assign w_term_ready = (r_state == StIdle) || (r_state == StNext);
   assign w_xfer       = bus.term_valid_i & w_term_ready;
   assign w_count_inc  = (CNT_WIDTH + 1)'(r_count) + (CNT_WIDTH + 1)'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_sum_nxt   = r_sum;
      w_term_nxt  = r_term;
      w_count_nxt = r_count;
      w_last_nxt  = r_last;
`ifdef FP_ACC_TIMEOUT_EN
      w_wdog_nxt    = r_wdog;
      w_timeout_nxt = r_timeout;
`endif
      case (r_state)
         StIdle: begin
            if (w_xfer) begin
               w_term_nxt  = bus.term_i;
               w_count_nxt = CNT_WIDTH'(1);
               w_last_nxt  = bus.term_last_i | (NUM_TERMS == 1);
               w_state_nxt = StIssue;
            end
         end
         StIssue: begin
`ifdef FP_ACC_TIMEOUT_EN
            w_wdog_nxt = '0;
`endif
            w_state_nxt = StWait;
         end
         StWait: begin
            // Done is a level; the first high cycle seen here completes the add.
            if (bus.add_done_i) begin
               w_sum_nxt   = bus.add_result_i;
               w_state_nxt = r_last ? StOut : StNext;
            end
`ifdef FP_ACC_TIMEOUT_EN
            else if (r_wdog == WdW'(TIMEOUT_CYCLES - 1)) begin
               // Give up on the adder and release the partial sum.
               w_timeout_nxt = 1'b1;
               w_state_nxt   = StOut;
            end else begin
               w_wdog_nxt = r_wdog + WdW'(1);
            end
`endif
         end
         StNext: begin
            if (w_xfer) begin
               w_term_nxt  = bus.term_i;
               w_count_nxt = w_count_inc[CNT_WIDTH-1:0];
               // Close the series at NUM_TERMS even without term_last_i.
               w_last_nxt  = bus.term_last_i |
                             (w_count_inc == (CNT_WIDTH + 1)'(NUM_TERMS));
               w_state_nxt = StIssue;
            end
         end
         StOut: begin
            if (bus.sum_ready_i) begin
               w_sum_nxt   = '0;
               w_count_nxt = '0;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clkn_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_sum   <= '0;
         r_term  <= '0;
         r_count <= '0;
         r_last  <= 1'b0;
`ifdef FP_ACC_TIMEOUT_EN
         r_wdog    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sum   <= w_sum_nxt;
         r_term  <= w_term_nxt;
         r_count <= w_count_nxt;
         r_last  <= w_last_nxt;
`ifdef FP_ACC_TIMEOUT_EN
         r_wdog    <= w_wdog_nxt;
         r_timeout <= w_timeout_nxt;
`endif
      end
   end

   // Operand A is the running sum itself; it only changes when leaving WAIT,
   // so both operands are stable for the whole add.
   assign bus.term_ready_o = w_term_ready;
   assign bus.add_a_o      = r_sum;
   assign bus.add_b_o      = r_term;
   assign bus.add_valid_o  = (r_state == StIssue);
   assign bus.sum_o        = r_sum;
   assign bus.sum_valid_o  = (r_state == StOut);
   assign bus.term_count_o = r_count;
   assign bus.busy_o       = (r_state != StIdle);
`ifdef FP_ACC_TIMEOUT_EN
   assign bus.timeout_o    = r_timeout;
`endif

endmodule

// File: tb/tb_fp32_series_accumulator.sv
// ----------------------------------------------------------------------------
// tb_fp32_series_accumulator
// Directed bench for fp32_series_accumulator with a behavioural FP32 adder
// (done 3 cycles after the start pulse) and a queue of expected sums.
// Build option: FP_ACC_TIMEOUT_EN adds the watchdog scenario.
// ----------------------------------------------------------------------------
module tb_fp32_series_accumulator;

   localparam int unsigned NumTerms = 4;
   localparam int unsigned CntW     = 4;
   localparam int unsigned Tmo      = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp32_series_accumulator_if #(.DATA_WIDTH(32), .CNT_WIDTH(CntW)) bus ();

   fp32_series_accumulator #(
      .DATA_WIDTH    (32),
      .NUM_TERMS     (NumTerms),
      .CNT_WIDTH     (CntW),
      .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .clkn_i(clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   // ---------------- FP32 <-> real helpers (normal numbers and +/-0) -------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // ---------------- behavioural adder ------------------------------------
   logic [31:0] m_res = 32'h0;
   logic [1:0]  m_cnt = 2'd0;
   logic        m_en  = 1'b1;

   always @(posedge clk) begin
      if (bus.add_valid_o) begin
         m_res <= r2f(f2r(bus.add_a_o) + f2r(bus.add_b_o));
         m_cnt <= 2'd3;
      end else if (m_cnt != 2'd0) begin
         m_cnt <= m_cnt - 2'd1;
      end
   end

   assign bus.add_done_i   = m_en && (m_cnt == 2'd1);
   assign bus.add_result_i = m_res;

   // ---------------- monitors ---------------------------------------------
   int          n_pulse    = 0;
   int          n_dbl      = 0;
   int          n_unstable = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] issue_a    = 32'hffff_ffff;
   logic [31:0] issue_b    = 32'hffff_ffff;

   always @(negedge clk) begin
      if (bus.add_valid_o) begin
         n_pulse <= n_pulse + 1;
         issue_a <= bus.add_a_o;
         issue_b <= bus.add_b_o;
         if (prev_valid) n_dbl <= n_dbl + 1;
      end else if (!rst && bus.busy_o && !bus.term_ready_o && !bus.sum_valid_o) begin
         // WAIT: operands must match what was presented at ISSUE
         if (bus.add_a_o !== issue_a || bus.add_b_o !== issue_b)
            n_unstable <= n_unstable + 1;
      end
      prev_valid <= bus.add_valid_o;
   end

   // ---------------- checking / stimulus tasks ----------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_term(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      bus.term_i       = d;
      bus.term_last_i  = l;
      bus.term_valid_i = 1'b1;
      while (!bus.term_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("term_accept", 64'(bus.term_ready_o), 64'd1);
      @(posedge clk);
      #1;
      bus.term_valid_i = 1'b0;
      bus.term_last_i  = 1'b0;
   endtask

   task automatic get_sum(input string tag, input logic [CntW-1:0] cnt, input int hold,
                          input logic drop_valid);
      int          n;
      logic [31:0] e;
      logic [31:0] s0;
      logic        ok;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.sum_valid_o && n < 500);
      chk({tag, "_valid"}, 64'(bus.sum_valid_o), 64'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
      chk({tag, "_sum"}, 64'(bus.sum_o), 64'(e));
      chk({tag, "_count"}, 64'(bus.term_count_o), 64'(cnt));
      if (hold > 0) begin
         s0 = bus.sum_o;
         ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.sum_o !== s0 || bus.sum_valid_o !== 1'b1 || bus.term_ready_o !== 1'b0)
               ok = 1'b0;
         end
         chk({tag, "_hold_stable"}, 64'(ok), 64'd1);
      end
      bus.sum_ready_i = 1'b1;
      if (drop_valid) bus.term_valid_i = 1'b0;
      @(posedge clk);
      #1;
      bus.sum_ready_i = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_flags"},
          64'({bus.busy_o, bus.sum_valid_o, bus.add_valid_o, bus.term_ready_o}), 64'b0001);
      chk({tag, "_ops"}, {bus.add_a_o, bus.add_b_o}, 64'd0);
      chk({tag, "_cnt_sum"}, 64'({bus.term_count_o, bus.sum_o}), 64'd0);
   endtask

   // ---------------- global time limit -------------------------------------
   initial begin
      #500000;
      $display("FAIL global_time_limit: observed no finish, required finish");
      $fatal(1, "time limit");
   end

   // ---------------- directed sequence -------------------------------------
   initial begin
      int p0;
      int n;
      logic seen;
      bus.term_i       = 32'h0;
      bus.term_valid_i = 1'b0;
      bus.term_last_i  = 1'b0;
      bus.sum_ready_i  = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("reset");
`ifdef FP_ACC_TIMEOUT_EN
      chk("reset_timeout", 64'(bus.timeout_o), 64'd0);
`endif

      // 1: 1.0 + 0.5 + 0.25
      p0 = n_pulse;
      exp_q.push_back(32'h3fe0_0000);
      send_term(32'h3f80_0000, 1'b0);
      send_term(32'h3f00_0000, 1'b0);
      send_term(32'h3e80_0000, 1'b1);
      get_sum("t1", CntW'(3), 0, 1'b1);
      chk("t1_pulses", 64'(n_pulse - p0), 64'd3);

      // 2: NUM_TERMS cap with term_last_i never set; 5th term starts a new series
      p0 = n_pulse;
      exp_q.push_back(32'h4080_0000);
      for (int i = 0; i < 4; i++) send_term(32'h3f80_0000, 1'b0);
      @(negedge clk);
      bus.term_i       = 32'h3f80_0000;
      bus.term_last_i  = 1'b1;
      bus.term_valid_i = 1'b1;
      exp_q.push_back(32'h3f80_0000);
      seen = 1'b0;
      n = 0;
      while (!bus.sum_valid_o && n < 300) begin
         if (bus.term_ready_o) seen = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("t2_ready_blocked", 64'(seen), 64'd0);
      get_sum("t2a", CntW'(4), 3, 1'b0);
      chk("t2_pulses", 64'(n_pulse - p0), 64'd4);
      @(posedge clk);
      #1;
      bus.term_valid_i = 1'b0;
      bus.term_last_i  = 1'b0;
      get_sum("t2b", CntW'(1), 0, 1'b1);

      // 3: downstream back-pressure for 10 cycles
      exp_q.push_back(32'h4040_0000);
      send_term(32'h4000_0000, 1'b0);
      send_term(32'h3f80_0000, 1'b1);
      get_sum("t3", CntW'(2), 10, 1'b1);

      // 4: reset in WAIT of the 2nd term, stale done afterwards
      send_term(32'h3f80_0000, 1'b0);
      send_term(32'h4000_0000, 1'b0);
      @(negedge clk);               // ISSUE
      @(negedge clk);               // WAIT
      chk("t4_in_wait", 64'({bus.busy_o, bus.term_ready_o, bus.sum_valid_o}), 64'b100);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("t4_after_rst");
      @(negedge clk);               // stale done is high during this cycle
      @(negedge clk);
      chk("t4_stale_ignored", 64'({bus.busy_o, bus.sum_valid_o, bus.sum_o}), 64'd0);
      exp_q.push_back(32'h3f80_0000);
      send_term(32'h3f80_0000, 1'b1);
      get_sum("t4", CntW'(1), 0, 1'b1);

      // 5: single term with term_valid_i held high throughout
      p0 = n_pulse;
      exp_q.push_back(32'h3e2a_aaab);
      @(negedge clk);
      bus.term_i       = 32'h3e2a_aaab;
      bus.term_last_i  = 1'b1;
      bus.term_valid_i = 1'b1;
      get_sum("t5", CntW'(1), 2, 1'b1);
      chk("t5_issue_a", 64'(issue_a), 64'd0);
      chk("t5_issue_b", 64'(issue_b), 64'h3e2a_aaab);
      chk("t5_pulses", 64'(n_pulse - p0), 64'd1);
      bus.term_last_i = 1'b0;

`ifdef FP_ACC_TIMEOUT_EN
      // 6: adder stops answering on the 2nd term
      send_term(32'h3f80_0000, 1'b0);
      n = 0;
      while (!bus.term_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      m_en = 1'b0;
      exp_q.push_back(32'h3f80_0000);
      send_term(32'h4000_0000, 1'b1);
      chk("t6_pre_timeout", 64'(bus.timeout_o), 64'd0);
      n = 0;
      do begin
         @(negedge clk);
         if (!bus.sum_valid_o && bus.busy_o && !bus.term_ready_o && !bus.add_valid_o) n++;
      end while (!bus.sum_valid_o && n < 200);
      chk("t6_wait_cycles", 64'(n), 64'(Tmo));
      chk("t6_timeout", 64'(bus.timeout_o), 64'd1);
      get_sum("t6", CntW'(2), 0, 1'b1);
      m_en = 1'b1;
      chk("t6_sticky", 64'(bus.timeout_o), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_clears", 64'(bus.timeout_o), 64'd0);
`endif

      chk("single_cycle_pulses", 64'(n_dbl), 64'd0);
      chk("operands_stable", 64'(n_unstable), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
